// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  // Bits needed to hold 0 .. value-1 (at least one bit).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Measurement bus of the frequency meter: signal/enable in, result out.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 27
);

  logic             sig_in;
  logic             en;
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output sig_in,
    output en,
    input  freq_out,
    input  freq_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  sig_in,
    input  en,
    output freq_out,
    output freq_valid,
    output overflow,
    output busy
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector.
// The pulse appears three clk edges after the asynchronous rise.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // synchronizer chain plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // one-cycle pulse on a synchronized low-to-high transition
  always_comb begin
    rise_pulse = r_sync2 & ~r_sync3;
  end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed window of GATE_CYCLES clocks
// and presents the count with a one-cycle valid strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  freq_meter_if.slave bus
);

  localparam int unsigned         GATE_W    = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  if (GATE_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 2 and CLK_HZ non-zero");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;
  logic [CNT_W-1:0]  r_freq_out;
  logic              r_overflow;
  logic              r_valid;
  logic              w_rise;
  logic              w_busy;
  logic              w_done;
  logic              w_gate_last;

  sync_edge_det u_sync_edge_det (
    .clk        (clk),
    .rst        (rst),
    .async_in   (bus.sig_in),
    .rise_pulse (w_rise)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next state and state-decoded flags; dropping en aborts ARM/GATE
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_gate_last  = (r_gate_cnt == GATE_LAST);
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.en) begin
          w_state_next = ARM;
        end
      end
      ARM: begin
        w_state_next = bus.en ? GATE : IDLE;
      end
      GATE: begin
        if (!bus.en) begin
          w_state_next = IDLE;
        end else if (w_gate_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = bus.en ? ARM : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // gate and saturating edge counters; edges outside GATE are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
        end
        ARM: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
        end
        GATE: begin
          if (!w_gate_last) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
          end
          if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) begin
              r_sat <= 1'b1;
            end else begin
              r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_gate_cnt <= r_gate_cnt;
        end
      endcase
    end
  end

  // result registers update only on leaving DONE, strobe alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      r_freq_out <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_freq_out <= r_edge_cnt;
        r_overflow <= r_sat;
      end
    end
  end

  assign bus.freq_out   = r_freq_out;
  assign bus.overflow   = r_overflow;
  assign bus.freq_valid = r_valid;
  assign bus.busy       = w_busy;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external or divided-down square wave by counting its rising edges over a fixed gate window of system-clock cycles.
- Sits downstream of the clock-divider blocks. A 1 Hz divider output fed in with GATE_CYCLES = CLK_HZ reads back 1.
- The result feeds the 7-segment/LED display path as a binary count, plus a one-cycle valid strobe.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- GATE_CYCLES, CLK_HZ, gate window length in clk cycles (1 s by default). Must be ≥ 2.
- CNT_W, 27, width of the edge counter and result.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  signal under measurement; asynchronous to clk.
- en  input  1  1 = measure continuously, 0 = stop/abort.
- freq_out  output  CNT_W  rising edges counted in the last completed gate.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- overflow  output  1  last completed gate saturated the counter.
- busy  output  1  high in ARM, GATE or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; freq_out = 0; freq_valid = 0; overflow = 0; busy = 0; gate and edge counters = 0; synchronizer flops = 0.
- Input path:
  - sig_in passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - An edge pulse is produced 3 clk cycles after the sig_in rise.
  - Resolvable input frequency is < CLK_HZ/2; sig_in must be high ≥ 1 clk and low ≥ 1 clk.
- FSM states: IDLE, ARM, GATE, DONE.
  - IDLE: counters held at 0. en = 1 → ARM.
  - ARM (1 cycle): clear gate_cnt and edge_cnt → GATE. Edge pulses in ARM are not counted.
  - GATE:
    - gate_cnt increments from 0 to GATE_CYCLES-1, one count per cycle.
    - Each cycle with an edge pulse increments edge_cnt.
    - An edge on the cycle gate_cnt = GATE_CYCLES-1 is included.
    - After that cycle → DONE.
  - DONE (1 cycle):
    - freq_out <= edge_cnt; overflow <= sat_flag; freq_valid = 1 for exactly this cycle's registered output.
    - Then → ARM if en = 1, else IDLE.
    - Continuous mode therefore has a fixed 2-cycle dead time (DONE + ARM) between gates; edges there are dropped.
- Saturation: edge_cnt stops at 2^CNT_W-1 and never wraps. sat_flag is set when an increment is requested at max; it is cleared in ARM.
- en = 0 during ARM or GATE: abort, next state IDLE.
  - No freq_valid is issued.
  - freq_out and overflow hold their previous values.
- en = 0 during DONE: result is still latched and strobed, then → IDLE.
- rst at any time overrides everything, including mid-gate and DONE, and returns all outputs to reset values on the next edge.
- freq_out and overflow change only in DONE. They are stable between strobes.
- Latency: freq_valid asserts GATE_CYCLES + 2 cycles after en is first sampled high (ARM + gate + DONE).

Decomposition:
- Package freq_meter_pkg:
  - state enum {IDLE, ARM, GATE, DONE};
  - DEFAULT_CLK_HZ = 50_000_000;
  - helper function clog2 for sizing gate_cnt = clog2(GATE_CYCLES).
- Sub-module sync_edge_det:
  - ports clk, rst, async_in, rise_pulse;
  - contains the 2-FF synchronizer plus edge detect;
  - reusable for the push-button inputs.

Test Plan:
- GATE_CYCLES = 100, CNT_W = 8, sig_in square wave with period 10 clk, en held 1 → every freq_valid shows freq_out = 10, overflow = 0, strobes 102 cycles apart.
- sig_in held constant 1 (then 0), en = 1 → freq_out = 0 each strobe, overflow = 0.
- CNT_W = 4, GATE_CYCLES = 100, sig_in period 4 → 25 edges saturate: freq_out = 15, overflow = 1. Then switch to period 20 → next full gate gives freq_out = 5, overflow = 0.
- Complete one gate (freq_out = 10), then drop en at gate_cnt = 50 → no freq_valid, freq_out stays 10, busy = 0 next cycle. Re-raise en → next strobe 102 cycles later.
- Assert rst for 1 cycle at gate_cnt = 70 → all outputs 0 next cycle, state IDLE. With en = 1, the first strobe arrives 102 cycles after rst release.
- Single sig_in pulse, high for 2 clk, placed so its edge pulse lands on the last gate cycle → counted (freq_out = 1). The same pulse landing in ARM → freq_out = 0.
